execute_iter: RTL and testbench

Parametrised execute stage with a real issue handshake. Single-cycle ALU operations complete in one clock. Unsigned divide and remainder run on an iterative radix-2 divider that back-pressures decode through `stall_o` until the result is written. The block sits between decode and the register-file write port and holds the architectural status flags.

---
 rtl/execute_iter.sv | 177 +++++++++++++++++
 tb/tb_execute_iter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_iter.sv
// Execute stage: single-cycle ALU plus an iterative radix-2 restoring divider.
// The divider holds decode off through stall_o until its result is written.
// The stage also owns the architectural {N,Z,C,V} flags.
module execute_iter #(
    parameter int WORD = 32,
    parameter int W_RD = 5,
    parameter int W_SH = $clog2(WORD)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            v_i,
    output logic            stall_o,
    input  logic            flush_i,
    input  logic [3:0]      op_i,
    input  logic [WORD-1:0] a_i,
    input  logic [WORD-1:0] b_i,
    input  logic            wb_i,
    input  logic [W_RD-1:0] rd_num_i,
    output logic            v_o,
    output logic            wb_o,
    output logic [W_RD-1:0] rd_num_o,
    output logic [WORD-1:0] rd_data_o,
    output logic [3:0]      status_o
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_DIVU = 4'd10;
    localparam logic [3:0] OP_REMU = 4'd11;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic [W_SH-1:0] cnt;
    logic [WORD-1:0] quo;      // dividend bits shift out of the top, quotient bits shift in at the bottom
    logic [WORD-1:0] rem;
    logic [WORD-1:0] dvs;
    logic            div_rem;
    logic            div_wb;
    logic [W_RD-1:0] div_rd;

    logic            acc;
    logic            is_div;
    logic [W_SH-1:0] sh;
    logic [WORD:0]   add_s;
    logic [WORD:0]   sub_s;
    logic [WORD-1:0] alu_res;
    logic            alu_c;
    logic            alu_v;
    logic            alu_ok;

    logic [WORD:0]   rem_sh;
    logic [WORD:0]   rem_diff;
    logic            q_bit;
    logic [WORD-1:0] rem_nxt;
    logic [WORD-1:0] quo_nxt;
    logic [WORD-1:0] div_res;

    assign stall_o = (state == BUSY);
    assign acc     = v_i & ~stall_o & ~flush_i;
    assign is_div  = (op_i == OP_DIVU) || (op_i == OP_REMU);
    assign sh      = b_i[W_SH-1:0];
    assign add_s   = {1'b0, a_i} + {1'b0, b_i};
    assign sub_s   = {1'b0, a_i} + {1'b0, ~b_i} + (WORD+1)'(1);

    // Single-cycle result and flag candidates; divide-by-zero also resolves here
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ok  = 1'b1;
        case (op_i)
            OP_ADD: begin
                alu_res = add_s[WORD-1:0];
                alu_c   = add_s[WORD];
                alu_v   = (a_i[WORD-1] == b_i[WORD-1]) && (add_s[WORD-1] != a_i[WORD-1]);
            end
            OP_SUB: begin
                alu_res = sub_s[WORD-1:0];
                alu_c   = sub_s[WORD];
                alu_v   = (a_i[WORD-1] != b_i[WORD-1]) && (sub_s[WORD-1] != a_i[WORD-1]);
            end
            OP_AND:  alu_res = a_i & b_i;
            OP_OR:   alu_res = a_i | b_i;
            OP_XOR:  alu_res = a_i ^ b_i;
            OP_SLL:  alu_res = a_i << sh;
            OP_SRL:  alu_res = a_i >> sh;
            OP_SRA:  alu_res = WORD'($signed(a_i) >>> sh);
            OP_SLT:  alu_res = {{(WORD-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU: alu_res = {{(WORD-1){1'b0}}, a_i < b_i};
            OP_DIVU: begin
                alu_res = '1;
                alu_v   = 1'b1;
            end
            OP_REMU: begin
                alu_res = a_i;
                alu_v   = 1'b1;
            end
            default: alu_ok = 1'b0;
        endcase
    end

    // One restoring step: the extra top bit of the difference is the borrow
    always_comb begin
        rem_sh   = {rem, quo[WORD-1]};
        rem_diff = rem_sh - {1'b0, dvs};
        q_bit    = ~rem_diff[WORD];
        rem_nxt  = q_bit ? rem_diff[WORD-1:0] : rem_sh[WORD-1:0];
        quo_nxt  = {quo[WORD-2:0], q_bit};
        div_res  = div_rem ? rem_nxt : quo_nxt;
    end

    // Divider FSM and result/flag registers; flush beats divider completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            quo       <= '0;
            rem       <= '0;
            dvs       <= '0;
            div_rem   <= 1'b0;
            div_wb    <= 1'b0;
            div_rd    <= '0;
            v_o       <= 1'b0;
            wb_o      <= 1'b0;
            rd_num_o  <= '0;
            rd_data_o <= '0;
            status_o  <= '0;
        end else begin
            v_o  <= 1'b0;
            wb_o <= 1'b0;
            if (flush_i) begin
                state <= IDLE;
            end else if (state == BUSY) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
                if (cnt == '0) begin
                    state     <= IDLE;
                    v_o       <= 1'b1;
                    wb_o      <= div_wb;
                    rd_num_o  <= div_rd;
                    rd_data_o <= div_res;
                    status_o  <= {div_res[WORD-1], div_res == '0, 2'b00};
                end else begin
                    cnt <= cnt - W_SH'(1);
                end
            end else if (acc) begin
                if (is_div && (b_i != '0)) begin
                    state   <= BUSY;
                    cnt     <= W_SH'(WORD-1);
                    quo     <= a_i;
                    rem     <= '0;
                    dvs     <= b_i;
                    div_rem <= (op_i == OP_REMU);
                    div_wb  <= wb_i;
                    div_rd  <= rd_num_i;
                end else begin
                    v_o       <= 1'b1;
                    wb_o      <= wb_i & alu_ok;
                    rd_num_o  <= rd_num_i;
                    rd_data_o <= alu_res;
                    if (alu_ok)
                        status_o <= {alu_res[WORD-1], alu_res == '0, alu_c, alu_v};
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_iter.sv
// Scoreboard bench for execute_iter: a WORD=32 instance checked against a
// software model, plus WORD=8 and WORD=64 instances for divider latency/values.
module tb_execute_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        v_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  op_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        wb_i = 1'b0;
    logic [4:0]  rd_num_i = '0;
    logic        stall_o, v_o, wb_o;
    logic [4:0]  rd_num_o;
    logic [31:0] rd_data_o;
    logic [3:0]  status_o;

    logic        v8 = 1'b0, wb8 = 1'b0, fl8 = 1'b0;
    logic [3:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [4:0]  rd8 = '0;
    logic        s8o, v8o, wb8o;
    logic [4:0]  rd8o;
    logic [7:0]  d8o;
    logic [3:0]  st8o;

    logic        v64 = 1'b0, wb64 = 1'b0, fl64 = 1'b0;
    logic [3:0]  op64 = '0;
    logic [63:0] a64 = '0, b64 = '0;
    logic [4:0]  rd64 = '0;
    logic        s64o, v64o, wb64o;
    logic [4:0]  rd64o;
    logic [63:0] d64o;
    logic [3:0]  st64o;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wb;
        logic [3:0]  st;
    } exp_t;

    exp_t        exp_q[$];
    logic [3:0]  mflags = '0;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    execute_iter #(.WORD(32)) dut (
        .clk(clk), .rst(rst), .v_i(v_i), .stall_o(stall_o), .flush_i(flush_i),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .wb_i(wb_i), .rd_num_i(rd_num_i),
        .v_o(v_o), .wb_o(wb_o), .rd_num_o(rd_num_o), .rd_data_o(rd_data_o),
        .status_o(status_o)
    );

    execute_iter #(.WORD(8)) dut8 (
        .clk(clk), .rst(rst), .v_i(v8), .stall_o(s8o), .flush_i(fl8),
        .op_i(op8), .a_i(a8), .b_i(b8), .wb_i(wb8), .rd_num_i(rd8),
        .v_o(v8o), .wb_o(wb8o), .rd_num_o(rd8o), .rd_data_o(d8o),
        .status_o(st8o)
    );

    execute_iter #(.WORD(64)) dut64 (
        .clk(clk), .rst(rst), .v_i(v64), .stall_o(s64o), .flush_i(fl64),
        .op_i(op64), .a_i(a64), .b_i(b64), .wb_i(wb64), .rd_num_i(rd64),
        .v_o(v64o), .wb_o(wb64o), .rd_num_o(rd64o), .rd_data_o(d64o),
        .status_o(st64o)
    );

    always #5 clk = ~clk;

    // Free-running cycle count for throughput measurement
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: computes the expected result and flags of one accepted op
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic wb, input logic [4:0] rd);
        logic [32:0] t;
        logic [31:0] r;
        logic        c, v, upd;
        exp_t        e;
        c = 1'b0; v = 1'b0; upd = 1'b1; r = '0; t = '0;
        case (op)
            4'd0: begin t = {1'b0, a} + {1'b0, b}; r = t[31:0]; c = t[32];
                        v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin t = {1'b0, a} + {1'b0, ~b} + 33'd1; r = t[31:0]; c = t[32];
                        v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $unsigned($signed(a) >>> b[4:0]);
            4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            4'd10: if (b == 0) begin r = 32'hFFFF_FFFF; v = 1'b1; end else r = a / b;
            4'd11: if (b == 0) begin r = a; v = 1'b1; end else r = a % b;
            default: upd = 1'b0;
        endcase
        if (upd) mflags = {r[31], r == 32'd0, c, v};
        e.rd = rd; e.data = r; e.wb = wb & upd; e.st = mflags;
        exp_q.push_back(e);
    endfunction

    // Present an op from a negedge and hold it until accepted; returns at the negedge after accept
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wb, input logic [4:0] rd);
        bit done = 0;
        op_i = op; a_i = a; b_i = b; wb_i = wb; rd_num_i = rd; v_i = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            if (!stall_o) begin
                model(op, a, b, wb, rd);
                @(posedge clk);
                done = 1;
            end
            @(negedge clk);
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL issue_timeout op=%0d still stalled, required accept within 200 cycles", op);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    endtask

    // Scoreboard: every valid result must match the oldest expected entry
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && v_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got rd=%0d data=%h wb=%b, required no result",
                         rd_num_o, rd_data_o, wb_o);
            end else begin
                e = exp_q.pop_front();
                if ({rd_num_o, rd_data_o, wb_o, status_o} !== {e.rd, e.data, e.wb, e.st}) begin
                    errors++;
                    $display("FAIL result got rd=%0d data=%h wb=%b st=%b, required rd=%0d data=%h wb=%b st=%b",
                             rd_num_o, rd_data_o, wb_o, status_o, e.rd, e.data, e.wb, e.st);
                end
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({v_o, wb_o, rd_num_o, rd_data_o, status_o, stall_o} !== 44'd0) begin
            errors++; $display("FAIL reset_state got v=%b wb=%b rd=%0d data=%h st=%b stall=%b, required all 0",
                               v_o, wb_o, rd_num_o, rd_data_o, status_o, stall_o);
        end
        rst = 1'b1;
        @(negedge clk);
        issue(4'd10, 32'd100, 32'd7, 1'b1, 5'd1);
        v_i = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL reset_pre_busy got stall=%b, required 1", stall_o);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({v_o, wb_o, rd_num_o, rd_data_o, status_o, stall_o} !== 44'd0) begin
            errors++; $display("FAIL reset_midstream got v=%b stall=%b data=%h st=%b, required all 0",
                               v_o, stall_o, rd_data_o, status_o);
        end
        exp_q.delete();
        mflags = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(4'd0, 32'd3, 32'd4, 1'b1, 5'd2);
        v_i = 1'b0;
        checks++;
        if (v_o !== 1'b1 || rd_data_o !== 32'd7) begin
            errors++; $display("FAIL reset_first_add got v=%b data=%h, required v=1 data=7", v_o, rd_data_o);
        end
        @(negedge clk);
        checks++;
        if (v_o !== 1'b0) begin
            errors++; $display("FAIL valid_drop got v=%b, required 0", v_o);
        end
    endtask

    task automatic test_alu();
        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd3);
        checks++;
        if (rd_data_o !== 32'h8000_0000 || status_o !== 4'b1001) begin
            errors++; $display("FAIL add_ovf got data=%h st=%b, required 80000000 st=1001", rd_data_o, status_o);
        end
        issue(4'd1, 32'd5, 32'd5, 1'b1, 5'd4);
        checks++;
        if (rd_data_o !== 32'd0 || status_o !== 4'b0110) begin
            errors++; $display("FAIL sub_zero got data=%h st=%b, required 0 st=0110", rd_data_o, status_o);
        end
        issue(4'd7, 32'h8000_0000, 32'd35, 1'b1, 5'd5);
        checks++;
        if (rd_data_o !== 32'hF000_0000) begin
            errors++; $display("FAIL sra_mask got data=%h, required f0000000", rd_data_o);
        end
        issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b1, 5'd6);
        issue(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd7);
        issue(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b1, 5'd8);
        issue(4'd5, 32'h0000_0003, 32'd31, 1'b1, 5'd9);
        issue(4'd6, 32'h8000_0000, 32'd4, 1'b1, 5'd10);
        issue(4'd13, 32'd1, 32'd2, 1'b1, 5'd11);
        checks++;
        if (v_o !== 1'b1 || wb_o !== 1'b0 || rd_data_o !== 32'd0) begin
            errors++; $display("FAIL reserved got v=%b wb=%b data=%h, required v=1 wb=0 data=0", v_o, wb_o, rd_data_o);
        end
        v_i = 1'b0;
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL alu_drain got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_divide();
        int off;
        for (int i = 0; i < 2; i++) begin
            issue(i == 0 ? 4'd10 : 4'd11, 32'd100, 32'd7, 1'b1, 5'(12 + i));
            v_i = 1'b0;
            off = 0;
            while (stall_o && off < 100) begin @(negedge clk); off++; end
            checks++;
            if (off != 32 || v_o !== 1'b1 || rd_data_o !== (i == 0 ? 32'd14 : 32'd2)) begin
                errors++; $display("FAIL divide_%0d got latency=%0d v=%b data=%0d, required latency=32 v=1 data=%0d",
                                   i, off, v_o, rd_data_o, i == 0 ? 14 : 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        issue(4'd10, 32'd1000, 32'd33, 1'b1, 5'd14);
        issue(4'd0, 32'd1, 32'd2, 1'b1, 5'd15);
        c0 = cyc;
        issue(4'd1, 32'd10, 32'd3, 1'b1, 5'd16);
        issue(4'd3, 32'h00F0, 32'h0F00, 1'b0, 5'd17);
        issue(4'd11, 32'd1000, 32'd0, 1'b1, 5'd18);
        issue(4'd2, 32'hFF00, 32'h0FF0, 1'b1, 5'd19);
        checks++;
        if (cyc - c0 != 4) begin
            errors++; $display("FAIL throughput got %0d cycles for 4 ops, required 4", cyc - c0);
        end
        v_i = 1'b0;
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_drain got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_div_zero();
        issue(4'd10, 32'd9, 32'd0, 1'b1, 5'd20);
        checks++;
        if (stall_o !== 1'b0 || v_o !== 1'b1 || rd_data_o !== 32'hFFFF_FFFF || status_o !== 4'b1001) begin
            errors++; $display("FAIL divu_zero got stall=%b v=%b data=%h st=%b, required 0 1 ffffffff 1001",
                               stall_o, v_o, rd_data_o, status_o);
        end
        issue(4'd11, 32'd9, 32'd0, 1'b1, 5'd21);
        checks++;
        if (stall_o !== 1'b0 || rd_data_o !== 32'd9 || status_o !== 4'b0001) begin
            errors++; $display("FAIL remu_zero got stall=%b data=%h st=%b, required 0 9 0001",
                               stall_o, rd_data_o, status_o);
        end
        v_i = 1'b0;
    endtask

    task automatic test_flush();
        op_i = 4'd10; a_i = 32'd100; b_i = 32'd7; wb_i = 1'b1; rd_num_i = 5'd22; v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (stall_o !== 1'b0 || v_o !== 1'b0 || wb_o !== 1'b0 || status_o !== mflags) begin
            errors++; $display("FAIL flush_busy got stall=%b v=%b wb=%b st=%b, required 0 0 0 st=%b",
                               stall_o, v_o, wb_o, status_o, mflags);
        end
        issue(4'd0, 32'd20, 32'd22, 1'b1, 5'd23);
        v_i = 1'b0;
        checks++;
        if (v_o !== 1'b1 || rd_data_o !== 32'd42) begin
            errors++; $display("FAIL flush_next_add got v=%b data=%0d, required 1 42", v_o, rd_data_o);
        end
        op_i = 4'd0; a_i = 32'd1; b_i = 32'd1; v_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0; flush_i = 1'b0;
        checks++;
        if (v_o !== 1'b0) begin
            errors++; $display("FAIL flush_presented got v=%b, required 0", v_o);
        end
        op_i = 4'd10; a_i = 32'd100; b_i = 32'd7; rd_num_i = 5'd24; v_i = 1'b1;
        @(negedge clk);
        v_i = 1'b0;
        repeat (31) @(negedge clk);
        checks++;
        if (stall_o !== 1'b1) begin
            errors++; $display("FAIL flush_final_busy got stall=%b, required 1", stall_o);
        end
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++;
        if (v_o !== 1'b0 || wb_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++; $display("FAIL flush_final got v=%b wb=%b stall=%b, required 0 0 0", v_o, wb_o, stall_o);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        logic [3:0]  ops[5] = '{4'd0, 4'd1, 4'd10, 4'd11, 4'd9};
        logic [3:0]  op;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 4)];
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            issue(op, $urandom, b, 1'($urandom), 5'($urandom));
        end
        v_i = 1'b0;
        drain();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL random_drain got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_word8();
        logic [7:0] a, b, r;
        logic [3:0] op;
        int off;
        for (int i = 0; i < 12; i++) begin
            a = 8'($urandom); b = (i % 4 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
            op = (i % 2) ? 4'd11 : 4'd10;
            r = (b == 0) ? ((op == 4'd10) ? 8'hFF : a) : ((op == 4'd10) ? a / b : a % b);
            a8 = a; b8 = b; op8 = op; rd8 = 5'(i); wb8 = 1'b1; v8 = 1'b1;
            @(negedge clk);
            v8 = 1'b0;
            off = 0;
            while (s8o && off < 100) begin @(negedge clk); off++; end
            checks++;
            if (v8o !== 1'b1 || d8o !== r || rd8o !== 5'(i) || off != ((b == 0) ? 0 : 8)) begin
                errors++; $display("FAIL w8_div op=%0d a=%0d b=%0d got v=%b data=%0d latency=%0d, required v=1 data=%0d latency=%0d",
                                   op, a, b, v8o, d8o, off, r, (b == 0) ? 0 : 8);
            end
        end
    endtask

    task automatic test_word64();
        logic [63:0] a, b, r;
        logic [3:0]  op;
        int off;
        for (int i = 0; i < 10; i++) begin
            a = {$urandom, $urandom};
            b = (i % 4 == 3) ? 64'd0 : (({$urandom, $urandom} >> $urandom_range(0, 62)) | 64'd1);
            op = (i % 2) ? 4'd11 : 4'd10;
            r = (b == 0) ? ((op == 4'd10) ? '1 : a) : ((op == 4'd10) ? a / b : a % b);
            a64 = a; b64 = b; op64 = op; rd64 = 5'(i); wb64 = 1'b1; v64 = 1'b1;
            @(negedge clk);
            v64 = 1'b0;
            off = 0;
            while (s64o && off < 200) begin @(negedge clk); off++; end
            checks++;
            if (v64o !== 1'b1 || d64o !== r || off != ((b == 0) ? 0 : 64)) begin
                errors++; $display("FAIL w64_div op=%0d a=%h b=%h got v=%b data=%h latency=%0d, required v=1 data=%h latency=%0d",
                                   op, a, b, v64o, d64o, off, r, (b == 0) ? 0 : 64);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_divide();
        test_back_to_back();
        test_div_zero();
        test_flush();
        test_random();
        test_word8();
        test_word64();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete, required completion before time limit");
        $fatal(1);
    end

endmodule
